// File: rtl/ddr_mem_tester.sv
// ddr_mem_tester: write-then-read pattern test over a word-address range
// on the SRAM-like port of a DDR3 wrapper. Each write or read is a
// request/release handshake on i_ready. Read data is compared against the
// same address-derived pattern. Mismatches are counted and the first failing
// address is recorded. A per-state watchdog stops the run if the port stalls.
module ddr_mem_tester #(
    parameter int          ADDR_W  = 24,
    parameter logic [15:0] SEED    = 16'hA5C3,
    parameter int          TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_calib_done,
    input  logic [ADDR_W-1:0] i_first,
    input  logic [ADDR_W-1:0] i_last,
    output logic [31:0]       o_Addr,
    output logic              o_CS,
    output logic              o_WE,
    output logic              o_L,
    output logic              o_U,
    output logic [15:0]       o_WR,
    input  logic [15:0]       i_RD,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [15:0]       o_err_cnt,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_WR_REQ,
        S_WR_REL,
        S_RD_REQ,
        S_RD_REL,
        S_DONE
    } state_t;

    state_t            state, nxt_state;
    logic [ADDR_W-1:0] addr, first_r, last_r;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit, in_xfer;
    logic              bad_range;

    // strobes from the FSM to the datapath registers
    logic start_run, addr_ld_first, addr_inc, rd_cmp, set_tmo;

    // Pattern: low half of the address, folded with the upper bits, XOR seed.
    // The address is zero-extended to 32 bits so upper bits above ADDR_W fold in as zero.
    function automatic logic [15:0] pattern(input logic [ADDR_W-1:0] a);
        logic [31:0] a32;
        a32 = 32'(a);
        return a32[15:0] ^ a32[31:16] ^ SEED;
    endfunction

    assign in_xfer = (state == S_WR_REQ) || (state == S_WR_REL) ||
                     (state == S_RD_REQ) || (state == S_RD_REL);
    assign tmo_hit = in_xfer && (tmo_cnt == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= nxt_state;
    end

    // Next-state logic, datapath strobes and the memory-port outputs
    always_comb begin
        nxt_state     = state;
        start_run     = 1'b0;
        addr_ld_first = 1'b0;
        addr_inc      = 1'b0;
        rd_cmp        = 1'b0;
        set_tmo       = 1'b0;
        o_CS          = 1'b0;
        o_WE          = 1'b0;
        o_WR          = 16'h0000;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                o_done = (state == S_DONE);
                if (i_start) begin
                    start_run = 1'b1;
                    nxt_state = (i_first > i_last) ? S_DONE : S_WAIT_CAL;
                end
            end
            S_WAIT_CAL: begin
                o_busy = 1'b1;
                if (i_calib_done) nxt_state = S_WR_REQ;
            end
            S_WR_REQ: begin
                o_busy = 1'b1;
                o_CS   = 1'b1;
                o_WE   = 1'b1;
                o_WR   = pattern(addr);
                if (i_ready) begin
                    nxt_state = S_WR_REL;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    nxt_state = S_DONE;
                end
            end
            S_WR_REL: begin
                o_busy = 1'b1;
                o_WR   = pattern(addr);
                if (!i_ready) begin
                    if (addr == last_r) begin
                        addr_ld_first = 1'b1;
                        nxt_state     = S_RD_REQ;
                    end else begin
                        addr_inc  = 1'b1;
                        nxt_state = S_WR_REQ;
                    end
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    nxt_state = S_DONE;
                end
            end
            S_RD_REQ: begin
                o_busy = 1'b1;
                o_CS   = 1'b1;
                if (i_ready) begin
                    rd_cmp    = 1'b1;
                    nxt_state = S_RD_REL;
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    nxt_state = S_DONE;
                end
            end
            S_RD_REL: begin
                o_busy = 1'b1;
                if (!i_ready) begin
                    if (addr == last_r) begin
                        nxt_state = S_DONE;
                    end else begin
                        addr_inc  = 1'b1;
                        nxt_state = S_RD_REQ;
                    end
                end else if (tmo_hit) begin
                    set_tmo   = 1'b1;
                    nxt_state = S_DONE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    assign o_L    = o_CS;
    assign o_U    = o_CS;
    assign o_Addr = 32'(addr);
    assign o_pass = o_done && !bad_range && !o_timeout && (o_err_cnt == 16'h0000);

    // Watchdog: restarts on every state change, counts only while a transfer is pending
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)                           tmo_cnt <= '0;
        else if (nxt_state != state || !in_xfer) tmo_cnt <= '0;
        else                                     tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Address counter and the latched test range
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr    <= '0;
            first_r <= '0;
            last_r  <= '0;
        end else if (start_run) begin
            addr    <= i_first;
            first_r <= i_first;
            last_r  <= i_last;
        end else if (addr_ld_first) begin
            addr <= first_r;
        end else if (addr_inc) begin
            addr <= addr + 1'b1;
        end
    end

    // Result flags: error count, first failing address, timeout, empty range
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_cnt        <= 16'h0000;
            o_first_err_addr <= '0;
            o_timeout        <= 1'b0;
            bad_range        <= 1'b0;
        end else if (start_run) begin
            o_err_cnt        <= 16'h0000;
            o_first_err_addr <= '0;
            o_timeout        <= 1'b0;
            bad_range        <= (i_first > i_last);
        end else begin
            if (set_tmo) o_timeout <= 1'b1;
            if (rd_cmp && (i_RD != pattern(addr))) begin
                if (o_err_cnt == 16'h0000)  o_first_err_addr <= addr;
                if (o_err_cnt != 16'hFFFF)  o_err_cnt        <= o_err_cnt + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_ddr_mem_tester.sv
// Bench for ddr_mem_tester. A behavioural memory answers the handshake
// three cycles after CS and can corrupt chosen addresses. Stimulus pushes
// the expected transaction list and the expected run result. Independent
// monitors compare each CS burst and each o_done rise against those queues.
module tb_ddr_mem_tester;
    localparam int          AW   = 24;
    localparam logic [15:0] SEED = 16'hA5C3;
    localparam int          TMO  = 16;

    logic          clk = 1'b0;
    logic          i_rst_n, i_start, i_calib_done, i_ready;
    logic [AW-1:0] i_first, i_last;
    logic [31:0]   o_Addr;
    logic          o_CS, o_WE, o_L, o_U;
    logic [15:0]   o_WR, i_RD;
    logic          o_busy, o_done, o_pass, o_timeout;
    logic [15:0]   o_err_cnt;
    logic [AW-1:0] o_first_err_addr;

    always #5 clk = ~clk;

    ddr_mem_tester #(.ADDR_W(AW), .SEED(SEED), .TIMEOUT(TMO)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_calib_done(i_calib_done),
        .i_first(i_first), .i_last(i_last), .o_Addr(o_Addr), .o_CS(o_CS), .o_WE(o_WE),
        .o_L(o_L), .o_U(o_U), .o_WR(o_WR), .i_RD(i_RD), .i_ready(i_ready),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr)
    );

    typedef struct { logic we; logic [31:0] addr; logic [15:0] wr; } txn_t;
    typedef struct { logic [15:0] err; logic [AW-1:0] fea; logic pass; logic tmo; } res_t;

    txn_t        exp_txn[$];
    res_t        exp_res[$];
    logic [15:0] mem[int unsigned];
    logic [15:0] bad[int unsigned];
    bit          never_ready = 1'b0;
    int          checks = 0, passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] model_pat(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ SEED;
    endfunction

    // Memory model: ready 3 cycles after CS, drops the cycle after CS falls
    int cs_cnt = 0;
    always @(posedge clk) begin
        if (o_CS && o_WE && i_ready) mem[o_Addr] = o_WR;
        if (o_CS && !o_WE)
            i_RD <= (mem.exists(o_Addr) ? mem[o_Addr] : 16'hDEAD) ^
                    (bad.exists(o_Addr) ? bad[o_Addr] : 16'h0000);
        i_ready <= o_CS && (cs_cnt >= 2) && !never_ready;
        cs_cnt  <= o_CS ? cs_cnt + 1 : 0;
    end

    // Transaction monitor: each CS burst matches the next expected access and holds steady
    logic        prev_cs = 1'b0;
    logic [48:0] held;
    txn_t        t;
    always @(negedge clk) begin
        if (o_CS && !prev_cs) begin
            if (exp_txn.size() == 0) begin
                chk("unexpected_cs", 1, 0);
            end else begin
                t = exp_txn.pop_front();
                chk("txn_we", o_WE, t.we);
                chk("txn_addr", o_Addr, t.addr);
                chk("txn_lanes", {o_L, o_U}, 2'b11);
                if (t.we) chk("txn_wdata", o_WR, t.wr);
            end
        end else if (o_CS && prev_cs) begin
            chk("cs_hold_stable", {o_WE, o_Addr, o_WR}, held);
        end
        prev_cs <= o_CS;
        held    <= {o_WE, o_Addr, o_WR};
    end

    // Result monitor: each rise of o_done matches the next expected run result
    logic prev_done = 1'b0;
    res_t r;
    always @(negedge clk) begin
        if (o_done && !prev_done) begin
            if (exp_res.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                r = exp_res.pop_front();
                chk("res_err_cnt", o_err_cnt, r.err);
                chk("res_first_err", o_first_err_addr, r.fea);
                chk("res_pass", o_pass, r.pass);
                chk("res_timeout", o_timeout, r.tmo);
                chk("res_idle_bus", {o_busy, o_CS}, 2'b00);
                if (r.tmo) exp_txn.delete();
                else chk("res_all_txns_seen", exp_txn.size(), 0);
            end
        end
        prev_done <= o_done;
    end

    // Reference: all writes in order, then all reads; errors wherever the model corrupts
    task automatic push_run(input longint first, input longint last, input bit tmo);
        res_t e;
        e.err = 0; e.fea = '0; e.tmo = tmo;
        if (tmo) begin
            exp_txn.push_back('{1'b1, 32'(first), model_pat(32'(first))});
        end else begin
            for (longint a = first; a <= last; a++)
                exp_txn.push_back('{1'b1, 32'(a), model_pat(32'(a))});
            for (longint a = first; a <= last; a++) begin
                exp_txn.push_back('{1'b0, 32'(a), 16'h0000});
                if (bad.exists(32'(a)) && bad[32'(a)] != 16'h0000) begin
                    if (e.err == 0) e.fea = AW'(a);
                    e.err++;
                end
            end
        end
        e.pass = (first <= last) && !tmo && (e.err == 0);
        exp_res.push_back(e);
    endtask

    task automatic start_pulse(input longint first, input longint last);
        @(negedge clk);
        i_first = AW'(first); i_last = AW'(last); i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!o_done && n < 5000) begin @(negedge clk); n++; end
        if (!o_done) chk({name, "_bounded_wait"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_run(input string name, input longint first, input longint last);
        int n;
        push_run(first, last, 1'b0);
        start_pulse(first, last);
        chk({name, "_busy"}, o_busy, 1);
        wait_done(name, n);
    endtask

    initial begin
        int n, len, cs_seen;
        longint f;
        i_rst_n = 1'b0; i_start = 1'b0; i_calib_done = 1'b1;
        i_first = '0; i_last = '0; i_RD = '0; i_ready = 1'b0;
        #3;
        chk("rst_ctrl", {o_CS, o_WE, o_L, o_U, o_busy, o_done, o_pass, o_timeout}, 8'h00);
        chk("rst_addr_wr", {o_Addr, o_WR}, 48'h0);
        chk("rst_err", {o_err_cnt, o_first_err_addr}, 40'h0);
        #20 i_rst_n = 1'b1;

        // empty range from IDLE: done the next cycle, no access
        exp_res.push_back('{16'h0, '0, 1'b0, 1'b0});
        start_pulse(5, 4);
        chk("bad_range_done_next", {o_done, o_busy, o_pass}, 3'b100);
        repeat (4) @(negedge clk);

        do_run("ideal_0_3", 0, 3);
        bad[2] = 16'h0001;
        do_run("corrupt_0_7", 0, 7);
        bad.delete();
        do_run("cross_64k", 32'hFFFE, 32'h10002);
        do_run("top_no_wrap", 32'hFFFFFC, 32'hFFFFFF);

        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(0, 12);
            f = (k % 3 == 2) ? (longint'(24'hFFFFFF) - len) : longint'($urandom_range(0, 200000));
            bad.delete();
            if ($urandom_range(0, 1)) bad[32'(f + $urandom_range(0, len))] = 16'($urandom_range(1, 65535));
            if ($urandom_range(0, 1)) bad[32'(f + $urandom_range(0, len))] = 16'($urandom_range(1, 65535));
            do_run("random", f, f + len);
        end
        bad.delete();

        // calibration held low: no access until it rises
        i_calib_done = 1'b0;
        push_run(0, 3, 1'b0);
        start_pulse(0, 3);
        cs_seen = 0;
        repeat (100) begin @(negedge clk); if (o_CS) cs_seen++; end
        chk("calib_low_no_cs", cs_seen, 0);
        i_calib_done = 1'b1;
        wait_done("calib", n);

        // stalled memory: watchdog ends the run
        never_ready = 1'b1;
        push_run(10, 12, 1'b1);
        start_pulse(10, 12);
        n = 0;
        while (!o_CS && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!o_done && n < 100) begin @(negedge clk); n++; end
        chk("timeout_latency_ok", (n <= 18) && o_done, 1);
        repeat (2) @(negedge clk);
        never_ready = 1'b0;

        // reset during a read request
        push_run(0, 5, 1'b0);
        start_pulse(0, 5);
        n = 0;
        while (!(o_CS && !o_WE) && n < 2000) begin @(negedge clk); n++; end
        chk("reached_rd_req", o_CS && !o_WE, 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {o_CS, o_WE, o_L, o_U, o_busy, o_done, o_pass, o_timeout}, 8'h00);
        chk("midrst_data", {o_Addr, o_WR, o_err_cnt}, 64'h0);
        exp_txn.delete();
        exp_res.delete();
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_run("after_reset", 0, 5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
